// File: rtl/decoder_pkg.sv
// Shared definitions for the cipher round sequencers (decoder and encoder).
package decoder_pkg;

    localparam int ROUNDS    = 24;
    localparam int NUM_STEPS = 5;

    // Bit positions of each step in the start/finish vectors.
    localparam int STEP_RC = 0;
    localparam int STEP_RE = 1;
    localparam int STEP_PE = 2;
    localparam int STEP_RO = 3;
    localparam int STEP_CP = 4;

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        RC_S = 4'd1,
        RC_W = 4'd2,
        RE_S = 4'd3,
        RE_W = 4'd4,
        PE_S = 4'd5,
        PE_W = 4'd6,
        RO_S = 4'd7,
        RO_W = 4'd8,
        CP_S = 4'd9,
        CP_W = 4'd10,
        DONE = 4'd11
    } state_t;

    function automatic logic is_active(input state_t s);
        return !(s == IDLE || s == DONE);
    endfunction

endpackage

// File: rtl/decoder_controller_round_counter.sv
// Holds the current file and round; rounds count down, files count up.
module round_counter
    import decoder_pkg::*;
#(
    parameter int ROUNDS = decoder_pkg::ROUNDS,
    parameter int FI_W   = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            advance,
    input  logic [FI_W-1:0] count_in,
    output logic [FI_W-1:0] file_index,
    output logic [4:0]      iteration,
    output logic            iter_zero,
    output logic            last_file
);

    localparam logic [4:0] ITER_TOP = 5'(ROUNDS - 1);

    logic [FI_W-1:0] count;
    logic [FI_W:0]   next_file;

    // One extra bit so the compare cannot wrap at the top of the index range.
    assign next_file = {1'b0, file_index} + (FI_W + 1)'(1);
    assign iter_zero = (iteration == 5'd0);
    assign last_file = (next_file >= {1'b0, count});

    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= '0;
            file_index <= '0;
            iteration  <= 5'd0;
        end else if (load) begin
            count      <= count_in;
            file_index <= '0;
            iteration  <= ITER_TOP;
        end else if (advance) begin
            if (!iter_zero) begin
                iteration <= iteration - 5'd1;
            end else if (!last_file) begin
                file_index <= next_file[FI_W-1:0];
                iteration  <= ITER_TOP;
            end
        end
    end

endmodule

// File: rtl/decoder_controller.sv
// Decoder round sequencer: rounds ROUNDS-1..0 per file, inverse steps RC,RE,PE,RO,CP.
module decoder_controller
    import decoder_pkg::*;
#(
    parameter int ROUNDS = decoder_pkg::ROUNDS,
    parameter int FI_W   = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [FI_W-1:0] file_count,
    output logic            busy,
    output logic            done,
    output logic [FI_W-1:0] file_index,
    output logic [4:0]      iteration,
    output logic            RC_start,
    output logic            IRE_start,
    output logic            IPE_start,
    output logic            IRO_start,
    output logic            ICP_start,
    input  logic            RC_finish,
    input  logic            IRE_finish,
    input  logic            IPE_finish,
    input  logic            IRO_finish,
    input  logic            ICP_finish
);

    state_t               state;
    state_t               next_state;
    logic [NUM_STEPS-1:0] start_vec;
    logic [NUM_STEPS-1:0] start_next;
    logic                 load;
    logic                 advance;
    logic                 iter_zero;
    logic                 last_file;

    assign load    = (state == IDLE) && start;
    assign advance = (state == CP_W) && ICP_finish;

    round_counter #(
        .ROUNDS (ROUNDS),
        .FI_W   (FI_W)
    ) u_round_counter (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .advance    (advance),
        .count_in   (file_count),
        .file_index (file_index),
        .iteration  (iteration),
        .iter_zero  (iter_zero),
        .last_file  (last_file)
    );

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: if (start) next_state = (file_count == '0) ? DONE : RC_S;
            RC_S: next_state = RC_W;
            RC_W: if (RC_finish) next_state = RE_S;
            RE_S: next_state = RE_W;
            RE_W: if (IRE_finish) next_state = PE_S;
            PE_S: next_state = PE_W;
            PE_W: if (IPE_finish) next_state = RO_S;
            RO_S: next_state = RO_W;
            RO_W: if (IRO_finish) next_state = CP_S;
            CP_S: next_state = CP_W;
            CP_W: if (ICP_finish) next_state = (iter_zero && last_file) ? DONE : RC_S;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it.
        start_next          = '0;
        start_next[STEP_RC] = (next_state == RC_S);
        start_next[STEP_RE] = (next_state == RE_S);
        start_next[STEP_PE] = (next_state == PE_S);
        start_next[STEP_RO] = (next_state == RO_S);
        start_next[STEP_CP] = (next_state == CP_S);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            start_vec <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= next_state;
            start_vec <= start_next;
            busy      <= is_active(next_state);
            done      <= (next_state == DONE);
        end
    end

    assign RC_start  = start_vec[STEP_RC];
    assign IRE_start = start_vec[STEP_RE];
    assign IPE_start = start_vec[STEP_PE];
    assign IRO_start = start_vec[STEP_RO];
    assign ICP_start = start_vec[STEP_CP];

endmodule

// File: tb/tb_decoder_controller.sv
// Randomized bench: step models with random latency, expected step list built per job.
module tb_decoder_controller;

    localparam int FI_W   = 10;
    localparam int ROUNDS = 24;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [FI_W-1:0] file_count;
    logic            busy;
    logic            done;
    logic [FI_W-1:0] file_index;
    logic [4:0]      iteration;
    logic            RC_start, IRE_start, IPE_start, IRO_start, ICP_start;
    logic [4:0]      fin;
    logic [4:0]      sv;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int step;
        int fi;
        int it;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    assign sv = {ICP_start, IRO_start, IPE_start, IRE_start, RC_start};

    decoder_controller #(
        .ROUNDS (ROUNDS),
        .FI_W   (FI_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .file_count (file_count),
        .busy       (busy),
        .done       (done),
        .file_index (file_index),
        .iteration  (iteration),
        .RC_start   (RC_start),
        .IRE_start  (IRE_start),
        .IPE_start  (IPE_start),
        .IRO_start  (IRO_start),
        .ICP_start  (ICP_start),
        .RC_finish  (fin[0]),
        .IRE_finish (fin[1]),
        .IPE_finish (fin[2]),
        .IRO_finish (fin[3]),
        .ICP_finish (fin[4])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One job. Cycle 0 is the start cycle; a step started in cycle s with latency L
    // finishes in cycle s+L (L=1 is the fastest legal step model).
    task automatic run_job(input int fc, input int lat_lo, input int lat_hi,
                           input bit noise, input int rst_iter, output int done_cyc);
        exp_t e;
        int   cyc, pend, cur, cur_it, cur_fi, fin_at, last_fin, stp, q;
        bit   reset_hit;
        exp_q.delete();
        for (int f = 0; f < fc; f++)
            for (int it = ROUNDS - 1; it >= 0; it--)
                for (int s = 0; s < 5; s++) begin
                    e.step = s; e.fi = f; e.it = it;
                    exp_q.push_back(e);
                end
        start = 1'b1;
        file_count = FI_W'(fc);
        @(posedge clk); #1;
        start = 1'b0;
        file_count = FI_W'($urandom);
        cyc = 1; pend = -1; cur = -1; cur_it = 0; cur_fi = 0; fin_at = 0;
        last_fin = 0; done_cyc = -1; reset_hit = 1'b0;
        while (cyc < 4000) begin
            fin = '0;
            start = 1'b0;
            if (cyc == last_fin + 1 && pend < 0)
                chk("step_or_done", 32'((sv != 0) || done), 1);
            if (done) begin
                chk("done_time", cyc, last_fin + 1);
                chk("left_steps", exp_q.size(), 0);
                chk("busy_at_done", 32'(busy), 0);
                chk("start_at_done", 32'(sv), 0);
                done_cyc = cyc;
                break;
            end
            chk("busy", 32'(busy), 1);
            if (sv != 0) begin
                stp = -1;
                for (int k = 4; k >= 0; k--) if (sv[k]) stp = k;
                chk("one_hot", $countones(sv), 1);
                if (exp_q.size() == 0) begin
                    chk("extra_start", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("step", stp, e.step);
                    chk("file_index", 32'(file_index), e.fi);
                    chk("iteration", 32'(iteration), e.it);
                    chk("start_time", cyc, last_fin + 1);
                    pend = e.step; cur = e.step; cur_it = e.it; cur_fi = e.fi;
                    fin_at = cyc + $urandom_range(lat_hi, lat_lo);
                end
            end else if (pend >= 0) begin
                chk("hold_fi", 32'(file_index), cur_fi);
                chk("hold_it", 32'(iteration), cur_it);
                if (rst_iter >= 0 && pend == 3 && cur_it == rst_iter) begin
                    rst = 1'b1;
                    @(posedge clk); #1;
                    rst = 1'b0;
                    chk("rst_busy", 32'(busy), 0);
                    chk("rst_done", 32'(done), 0);
                    chk("rst_starts", 32'(sv), 0);
                    chk("rst_fi", 32'(file_index), 0);
                    chk("rst_it", 32'(iteration), 0);
                    for (int k = 0; k < 6; k++) begin
                        @(posedge clk); #1;
                        chk("rst_quiet", 32'({sv, done, busy}), 0);
                    end
                    reset_hit = 1'b1;
                    break;
                end
            end
            if (pend >= 0 && cyc == fin_at) begin
                fin[pend] = 1'b1;
                last_fin = cyc;
                pend = -1;
            end
            if (noise) begin
                if ($urandom_range(3, 0) == 0) begin
                    q = int'($urandom_range(4, 0));
                    if (q != cur) fin[q] = 1'b1;
                end
                start = ($urandom_range(9, 0) == 0);
            end
            @(posedge clk); #1;
            cyc++;
        end
        fin = '0;
        start = 1'b0;
        if (!reset_hit) begin
            if (done_cyc < 0) chk("timeout", 1, 0);
            @(posedge clk); #1;
            chk("post_done", 32'({done, busy, sv}), 0);
        end
    endtask

    initial begin
        int d;
        rst = 1'b1; start = 1'b0; fin = '0; file_count = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_starts", 32'(sv), 0);
        chk("reset_fi", 32'(file_index), 0);
        chk("reset_it", 32'(iteration), 0);
        rst = 1'b0;

        run_job(1, 3, 3, 1'b0, -1, d);
        run_job(3, 3, 3, 1'b0, -1, d);
        run_job(0, 1, 1, 1'b0, -1, d);
        chk("fc0_done_cycle", d, 1);
        run_job(1, 1, 1, 1'b0, -1, d);
        chk("zero_lat_done_cycle", d, 241);
        run_job(2, 1, 4, 1'b1, -1, d);
        run_job(1, 1, 3, 1'b1, 10, d);
        run_job(1, 1, 2, 1'b0, -1, d);
        for (int j = 0; j < 4; j++) begin
            run_job(int'($urandom_range(3, 0)), 1, int'($urandom_range(4, 1)), 1'b1, -1, d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/decoder_controller.md
# decoder_controller

Round sequencer for the decoder side of the Keccak-style file cipher. It undoes what the encoder does: for each file it runs all 24 rounds in reverse order (iteration 23 down to 0). Within each round it applies the inverse steps in reverse order: addRC (self-inverse), inverse revaluate, inverse permute, inverse rotate, inverse colParity. It drives the start/finish handshakes of those step modules and supplies `file_index` and `iteration` to them.

## Interface
Parameters:
- `ROUNDS`, 24: rounds per file; iteration counts from `ROUNDS-1` down to 0.
- `FI_W`, 10: width of `file_index` and `file_count`.

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  one-cycle request to decode files 0..`file_count`-1.
- `file_count`  in  `FI_W`  number of files; sampled only when `start` is accepted.
- `busy`  out  1  high from the cycle after `start` is accepted through the cycle of `done`, exclusive of the `done` cycle.
- `done`  out  1  one-cycle pulse when the whole job is finished.
- `file_index`  out  `FI_W`  current file.
- `iteration`  out  5  current round.
- `RC_start`, `IRE_start`, `IPE_start`, `IRO_start`, `ICP_start`  out  1 each  one-cycle step start pulses.
- `RC_finish`, `IRE_finish`, `IPE_finish`, `IRO_finish`, `ICP_finish`  in  1 each  one-cycle step completion pulses.

## Operation
FSM states:
- IDLE
- RC_S, RC_W
- RE_S, RE_W
- PE_S, PE_W
- RO_S, RO_W
- CP_S, CP_W
- DONE

Transitions and behaviour:
- IDLE: when `start`=1, latch `file_count`, set `file_index`=0 and `iteration`=`ROUNDS-1`.
  - If `file_count`=0, go to DONE.
  - Otherwise go to RC_S.
- Each X_S state: assert the matching `*_start` for exactly that cycle, then go unconditionally to X_W.
- Each X_W state: wait for the matching `*_finish`. On it, advance to the next step's X_S: RC→RE→PE→RO→CP.
- CP_W on `ICP_finish`:
  - `iteration`>0: decrement `iteration`, go to RC_S.
  - `iteration`=0 and `file_index`+1 < latched count: increment `file_index`, reload `iteration`=`ROUNDS-1`, go to RC_S.
  - Otherwise go to DONE.
- DONE: `done`=1 for one cycle, then IDLE.

Rules:
- `file_index` and `iteration` are held stable from an X_S cycle until that step's finish is consumed.
- Only the finish that matches the current wait state is honoured; any other finish is ignored.
- A finish seen during an X_S state is ignored; step modules never finish in their start cycle.
- `start` is ignored in every state other than IDLE; `file_count` changes during a job have no effect.
- All outputs are registered.

## Timing
- Reset values: state IDLE; `busy`, `done`, all `*_start` = 0; `file_index`=0; `iteration`=0.
- Reset mid-job: returns to IDLE on the next edge. No further start pulses; no `done`.
- `start` accepted at cycle 0: `RC_start`=1 at cycle 1, with `iteration`=23 and `file_index`=0. `busy` is 1 from cycle 1.
- Finish at cycle m: the next step's start is at m+1. Sequencer overhead is 2 cycles per step (start cycle plus consume cycle), excluding step latency.
- `ICP_finish` at cycle m: the next `RC_start` is at m+1 with the updated `iteration`/`file_index`, or `done` is at m+1.
- `file_count`=0: `done` at cycle 1, no step starts, `busy` never high.
- Back-to-back jobs: a `start` in the cycle after `done` is accepted.

## Structure
- Shared package `decoder_pkg`: FSM state enum, `ROUNDS`, and the step order constants. The encoder controller reuses the same enum and constants.
- Natural sub-module: `round_counter`, holding `iteration` and `file_index` with load, decrement/wrap, increment and last-detect.
- Datapath-level wiring of the inverse step modules (`addRC`, `invRevaluate`, `invPermute`, `invRotate`, `invColParity`) sits in `decoder_datapath`, not in this block.

## Test plan
- Single file, `file_count`=1, each step model finishing 3 cycles after its start → exactly 120 start pulses in order RC,IRE,IPE,IRO,ICP repeated. `iteration` goes 23..0. `done` once.
- `file_count`=3 → `file_index` 0,1,2, `iteration` reloads to 23 at each file change, 360 start pulses, single `done`.
- `file_count`=0 → `done` at cycle 1, no `*_start`, `busy` stays 0.
- Spurious `IPE_finish` during RC_W, and `start` pulse mid-job → no state change, no extra start pulses, no restart.
- `rst` asserted during RO_W of iteration 10 → next cycle all outputs at reset values. A new `start` then begins at `iteration`=23, `file_index`=0.
- Zero-latency step models (finish in the cycle after start) → each step occupies 2 cycles. One file completes with `done` at cycle 241.
